rf_wb_scheduler: RTL and testbench
==================================

// Module: rf_wb_scheduler
// PURPOSE
//  Writeback scheduler and scoreboard for the 32x32 register file (2 read ports, 1 write port).
//  - Arbitrates NREQ writeback sources (ALU, load, mul/div) onto the single write port.
//  - Tracks pending destination registers so decode can detect RAW and WAW hazards.
//  - Sits between the EX/MEM/WB stages and the register file.
// PARAMETERS
//  NREQ    3   number of writeback requesters; index 0 wins ties after reset
//  ADDR_W  5   register address width
//  DATA_W  32  register data width
// PORTS
//  clk          in   1            clock; all state updates on posedge
//  reset        in   1            synchronous, active-high reset
//  issue_valid  in   1            decode issues an instruction that writes issue_dest
//  issue_dest   in   ADDR_W       destination register of the issued instruction; 0 = no write
//  issue_ready  out  1            0 when issue_dest!=0 and busy[issue_dest] (WAW hold)
//  wb_valid     in   NREQ         requester i holds a result
//  wb_ready     out  NREQ         one-hot grant; transfer occurs when wb_valid[i]&wb_ready[i]
//  wb_addr      in   NREQ*ADDR_W  per-requester destination, slice i = [i*ADDR_W +: ADDR_W]
//  wb_data      in   NREQ*DATA_W  per-requester data, slice i = [i*DATA_W +: DATA_W]
//  rf_we        out  1            register-file write enable (registered)
//  rf_waddr     out  ADDR_W       register-file write address (registered)
//  rf_wdata     out  DATA_W       register-file write data (registered)
//  raddr1/2     in   ADDR_W       decode read addresses
//  stall1/2     out  1            RAW hazard on read port 1/2 (combinational)
//  byp_hit1/2   out  1            bypass valid for read port 1/2 (only with RF_WB_BYPASS_EN)
//  byp_data1/2  out  DATA_W       bypass data for read port 1/2 (only with RF_WB_BYPASS_EN)
// BEHAVIOUR
//  Reset: busy[31:0]=0, rr_ptr=0, rf_we=0, rf_waddr=0, rf_wdata=0.
//   wb_ready=0 while reset is high; in-flight requests are dropped and requesters re-present.
//  Arbitration: round-robin, searching from rr_ptr upward with wrap.
//   - At most one wb_ready bit is set per cycle, and only when the matching wb_valid is set.
//   - There is no downstream backpressure, so any valid request is granted.
//   - After a grant to index g, rr_ptr = (g+1) mod NREQ; with no grant, rr_ptr holds.
//  Write port: 1-cycle latency.
//   - Granted in cycle T: rf_we/rf_waddr/rf_wdata are valid in T+1; the regfile commits at the end of T+1.
//   - A grant with wb_addr==0 is consumed, but rf_we stays 0 in T+1.
//   - With no grant, rf_we=0 next cycle and rf_waddr/rf_wdata hold.
//  Scoreboard:
//   - Set busy[d] on issue_valid & issue_ready & d!=0.
//   - Clear busy[rf_waddr] in any cycle with rf_we=1.
//   - Set and clear of the same register in the same cycle: set wins.
//   - busy[0] is always 0.
//  Hazards: stallN = (raddrN!=0) & busy[raddrN], except as modified by RF_WB_BYPASS_EN.
//   - busy stays 1 during the rf_we cycle; the regfile read returns the new value from the following cycle.
//  issue_ready is independent of wb traffic in the same cycle. A busy register clearing this cycle is still reported busy.
// CONFIGURATION
//  RF_WB_BYPASS_EN defined:
//   - bypN hit = rf_we & (rf_waddr==raddrN) & raddrN!=0; byp_dataN = rf_wdata.
//   - stallN is suppressed on a bypass hit.
//  Not defined: byp_hitN=0, byp_dataN=0, and stallN holds through the rf_we cycle.
// STRUCTURE
//  Package rf_ctrl_pkg:
//   - constants RF_ADDR_W=5, RF_DATA_W=32, RF_NUM=32, RF_ZERO=5'd0
//   - typedef rf_addr_t, rf_data_t
//  Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs one-hot gnt and encoded gnt_idx; purely combinational.
//  The pointer register, the output register and the scoreboard live in rf_wb_scheduler.
// TESTING
//  1. Reset, then issue_dest=5, then wb0 writes r5=0x1234.
//     -> stall on raddr1=5 until the rf_we cycle; rf_waddr=5 and rf_wdata=0x1234 one cycle after the grant; busy[5]=0 after that.
//  2. wb_valid=3'b111 held for 6 cycles.
//     -> wb_ready sequence 001,010,100,001,010,100; exactly one rf_we per cycle.
//  3. issue_valid with dest=0 and wb grant with addr=0.
//     -> busy unchanged, issue_ready=1, rf_we=0 in the following cycle.
//  4. Issue r7, then issue r7 again while pending.
//     -> issue_ready=0 until r7 clears; the same-cycle issue-r7 plus rf_we-r7 leaves busy[7]=1.
//  5. Reset asserted while wb_valid=3'b011 and busy[3]=1.
//     -> next cycle rf_we=0, busy all 0, wb_ready=0 during reset, grant to index 0 first after release.
//  6. RF_WB_BYPASS_EN: rf_we to r9=0xCAFE with raddr2=9.
//     -> stall2=0, byp_hit2=1, byp_data2=0xCAFE; without the macro stall2=1 in that cycle.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared register-file constants and types for the writeback scheduler.
// Optional bypass feature in the scheduler is enabled by defining RF_WB_BYPASS_EN.
package rf_ctrl_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;
    localparam int RF_NUM    = 32;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

    localparam rf_addr_t RF_ZERO = 5'd0;

endpackage

// File: rtl/rf_wb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr
// (with wrap) receives a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    // Rotating priority search starting from ptr.
    always_comb begin
        int  idx;
        logic found;
        gnt     = {N{1'b0}};
        gnt_idx = {IDX_W{1'b0}};
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler and pending-destination scoreboard for the register file.
// Define RF_WB_BYPASS_EN to forward the in-flight write to decode read ports.
module rf_wb_scheduler
    import rf_ctrl_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    input  logic [ADDR_W-1:0]      issue_dest,
    output logic                   issue_ready,
    input  logic [NREQ-1:0]        wb_valid,
    output logic [NREQ-1:0]        wb_ready,
    input  logic [NREQ*ADDR_W-1:0] wb_addr,
    input  logic [NREQ*DATA_W-1:0] wb_data,
    output logic                   rf_we,
    output logic [ADDR_W-1:0]      rf_waddr,
    output logic [DATA_W-1:0]      rf_wdata,
    input  logic [ADDR_W-1:0]      raddr1,
    input  logic [ADDR_W-1:0]      raddr2,
    output logic                   stall1,
    output logic                   stall2,
    output logic                   byp_hit1,
    output logic                   byp_hit2,
    output logic [DATA_W-1:0]      byp_data1,
    output logic [DATA_W-1:0]      byp_data2
);

    localparam int NREG  = 1 << ADDR_W;
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [NREG-1:0]   busy_q, busy_d;

    logic [NREQ-1:0]   arb_gnt_s;
    logic [IDX_W-1:0]  gnt_idx_s;
    logic              any_gnt_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic              issue_fire_s;

    rr_arbiter #(.N(NREQ), .IDX_W(IDX_W)) u_arb (
        .req     (wb_valid),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // Grant gating and selection of the winning requester's payload.
    always_comb begin
        sel_addr_s = {ADDR_W{1'b0}};
        sel_data_s = {DATA_W{1'b0}};
        if (reset) begin
            wb_ready  = {NREQ{1'b0}};
            any_gnt_s = 1'b0;
        end else begin
            wb_ready  = arb_gnt_s;
            any_gnt_s = |arb_gnt_s;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt_s[i]) begin
                sel_addr_s = wb_addr[i*ADDR_W +: ADDR_W];
                sel_data_s = wb_data[i*DATA_W +: DATA_W];
            end else begin
                sel_addr_s = sel_addr_s;
            end
        end
    end

    // Next-state for pointer and write-port register; a grant to r0 is consumed silently.
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (any_gnt_s) begin
            if (gnt_idx_s == IDX_W'(NREQ - 1)) begin
                rr_ptr_d = {IDX_W{1'b0}};
            end else begin
                rr_ptr_d = gnt_idx_s + {{(IDX_W-1){1'b0}}, 1'b1};
            end
            if (sel_addr_s != {ADDR_W{1'b0}}) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = sel_addr_s;
                rf_wdata_d = sel_data_s;
            end else begin
                rf_we_d = 1'b0;
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Scoreboard: a busy register stays busy through its write cycle, so issue_ready ignores wb traffic.
    always_comb begin
        issue_ready  = (issue_dest == {ADDR_W{1'b0}}) || !busy_q[issue_dest];
        issue_fire_s = issue_valid && issue_ready && (issue_dest != {ADDR_W{1'b0}});
        busy_d       = busy_q;
        if (rf_we_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end else begin
            busy_d = busy_d;
        end
        if (issue_fire_s) begin
            busy_d[issue_dest] = 1'b1;
        end else begin
            busy_d = busy_d;
        end
        busy_d[0] = 1'b0;
    end

    // Hazard detection and optional forwarding of the in-flight write.
    always_comb begin
`ifdef RF_WB_BYPASS_EN
        byp_hit1  = rf_we_q && (rf_waddr_q == raddr1) && (raddr1 != {ADDR_W{1'b0}});
        byp_hit2  = rf_we_q && (rf_waddr_q == raddr2) && (raddr2 != {ADDR_W{1'b0}});
        byp_data1 = rf_wdata_q;
        byp_data2 = rf_wdata_q;
`else
        byp_hit1  = 1'b0;
        byp_hit2  = 1'b0;
        byp_data1 = {DATA_W{1'b0}};
        byp_data2 = {DATA_W{1'b0}};
`endif
        stall1 = (raddr1 != {ADDR_W{1'b0}}) && busy_q[raddr1] && !byp_hit1;
        stall2 = (raddr2 != {ADDR_W{1'b0}}) && busy_q[raddr2] && !byp_hit2;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= {IDX_W{1'b0}};
            rf_we_q    <= 1'b0;
            rf_waddr_q <= {ADDR_W{1'b0}};
            rf_wdata_q <= {DATA_W{1'b0}};
            busy_q     <= {NREG{1'b0}};
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed self-checking bench for rf_wb_scheduler (default and RF_WB_BYPASS_EN builds).
module tb_rf_wb_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_ready;
    logic [2:0]  wb_valid;
    logic [2:0]  wb_ready;
    logic [14:0] wb_addr;
    logic [95:0] wb_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  raddr1, raddr2;
    logic        stall1, stall2, byp_hit1, byp_hit2;
    logic [31:0] byp_data1, byp_data2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rf_wb_scheduler dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_dest(issue_dest), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .raddr1(raddr1), .raddr2(raddr2), .stall1(stall1), .stall2(stall2),
        .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; inputs change 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_wb(input int i, input logic [4:0] a, input logic [31:0] d);
        wb_addr[i*5 +: 5]   = a;
        wb_data[i*32 +: 32] = d;
    endtask

    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_dest = 5'd0;
        wb_valid = 3'b000; wb_addr = 15'd0; wb_data = 96'd0;
        raddr1 = 5'd0; raddr2 = 5'd0;
        tick(); tick();
        reset = 1'b0;
        settle();
        // 1. reset state and single writeback of r5
        chk("rst_rf_we", rf_we, 1'b0);
        chk("rst_rf_waddr", rf_waddr, 5'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
        chk("rst_wb_ready", wb_ready, 3'b000);
        issue_valid = 1'b1; issue_dest = 5'd5; raddr1 = 5'd5;
        settle();
        chk("t1_issue_ready", issue_ready, 1'b1);
        chk("t1_stall_before", stall1, 1'b0);
        tick();
        issue_valid = 1'b0;
        settle();
        chk("t1_stall_pending", stall1, 1'b1);
        wb_valid = 3'b001; set_wb(0, 5'd5, 32'h1234);
        settle();
        chk("t1_wb_ready", wb_ready, 3'b001);
        tick();
        wb_valid = 3'b000;
        settle();
        chk("t1_rf_we", rf_we, 1'b1);
        chk("t1_rf_waddr", rf_waddr, 5'd5);
        chk("t1_rf_wdata", rf_wdata, 32'h1234);
`ifdef RF_WB_BYPASS_EN
        chk("t1_stall_wecyc", stall1, 1'b0);
        chk("t1_byp_hit1", byp_hit1, 1'b1);
`else
        chk("t1_stall_wecyc", stall1, 1'b1);
        chk("t1_byp_hit1", byp_hit1, 1'b0);
`endif
        tick();
        settle();
        chk("t1_rf_we_after", rf_we, 1'b0);
        chk("t1_stall_cleared", stall1, 1'b0);
        chk("t1_waddr_hold", rf_waddr, 5'd5);

        // 2. round-robin with all three requesting (pointer restarted via reset)
        reset = 1'b1; tick(); reset = 1'b0;
        wb_valid = 3'b111;
        set_wb(0, 5'd1, 32'hA0); set_wb(1, 5'd2, 32'hA1); set_wb(2, 5'd3, 32'hA2);
        settle();
        chk("t2_g0", wb_ready, 3'b001);
        tick(); settle();
        chk("t2_g1", wb_ready, 3'b010);
        chk("t2_we1", rf_we, 1'b1); chk("t2_addr1", rf_waddr, 5'd1);
        tick(); settle();
        chk("t2_g2", wb_ready, 3'b100);
        chk("t2_we2", rf_we, 1'b1); chk("t2_addr2", rf_waddr, 5'd2);
        tick(); settle();
        chk("t2_g3", wb_ready, 3'b001);
        chk("t2_we3", rf_we, 1'b1); chk("t2_data3", rf_wdata, 32'hA2);
        tick(); settle();
        chk("t2_g4", wb_ready, 3'b010);
        chk("t2_we4", rf_we, 1'b1); chk("t2_addr4", rf_waddr, 5'd1);
        tick(); settle();
        chk("t2_g5", wb_ready, 3'b100);
        chk("t2_we5", rf_we, 1'b1); chk("t2_addr5", rf_waddr, 5'd2);
        tick();
        wb_valid = 3'b000;
        settle();
        chk("t2_we6", rf_we, 1'b1); chk("t2_addr6", rf_waddr, 5'd3);
        chk("t2_idle_ready", wb_ready, 3'b000);
        tick(); settle();
        chk("t2_we_idle", rf_we, 1'b0);

        // 3. dest 0 issue and addr 0 grant (pointer is 0 here)
        issue_valid = 1'b1; issue_dest = 5'd0;
        wb_valid = 3'b001; set_wb(0, 5'd0, 32'hDEAD);
        settle();
        chk("t3_issue_ready", issue_ready, 1'b1);
        chk("t3_wb_ready", wb_ready, 3'b001);
        tick();
        issue_valid = 1'b0; wb_valid = 3'b000; raddr1 = 5'd0;
        settle();
        chk("t3_rf_we", rf_we, 1'b0);
        chk("t3_stall_r0", stall1, 1'b0);

        // 4. WAW hold on r7 (pointer is 1 here)
        issue_valid = 1'b1; issue_dest = 5'd7;
        settle();
        chk("t4_first_ready", issue_ready, 1'b1);
        tick(); settle();
        chk("t4_hold_a", issue_ready, 1'b0);
        tick();
        wb_valid = 3'b010; set_wb(1, 5'd7, 32'h77);
        settle();
        chk("t4_hold_b", issue_ready, 1'b0);
        chk("t4_wb_ready", wb_ready, 3'b010);
        tick();
        wb_valid = 3'b000;
        settle();
        chk("t4_rf_we", rf_we, 1'b1);
        chk("t4_rf_waddr", rf_waddr, 5'd7);
        chk("t4_hold_wecyc", issue_ready, 1'b0);
        tick(); settle();
        chk("t4_ready_cleared", issue_ready, 1'b1);
        tick();
        issue_valid = 1'b0; raddr1 = 5'd7;
        settle();
        chk("t4_reissued_busy", stall1, 1'b1);

        // 5. reset with traffic in flight and r3 busy (pointer is 2 here)
        issue_valid = 1'b1; issue_dest = 5'd3;
        tick();
        issue_valid = 1'b0; raddr1 = 5'd3; raddr2 = 5'd7;
        settle();
        chk("t5_r3_busy", stall1, 1'b1);
        wb_valid = 3'b011; set_wb(0, 5'd3, 32'h33); set_wb(1, 5'd4, 32'h44);
        reset = 1'b1;
        settle();
        chk("t5_ready_in_reset", wb_ready, 3'b000);
        tick(); settle();
        chk("t5_rf_we", rf_we, 1'b0);
        chk("t5_busy3_clr", stall1, 1'b0);
        chk("t5_busy7_clr", stall2, 1'b0);
        chk("t5_ready_in_reset2", wb_ready, 3'b000);
        reset = 1'b0;
        settle();
        chk("t5_first_grant", wb_ready, 3'b001);
        tick(); settle();
        chk("t5_rf_waddr", rf_waddr, 5'd3);
        chk("t5_second_grant", wb_ready, 3'b010);
        tick();
        wb_valid = 3'b000;

        // 6. bypass of r9 on read port 2 (pointer is 2 here)
        issue_valid = 1'b1; issue_dest = 5'd9; raddr2 = 5'd9;
        tick();
        issue_valid = 1'b0;
        wb_valid = 3'b100; set_wb(2, 5'd9, 32'hCAFE);
        settle();
        chk("t6_stall_pending", stall2, 1'b1);
        chk("t6_wb_ready", wb_ready, 3'b100);
        tick();
        wb_valid = 3'b000;
        settle();
        chk("t6_rf_wdata", rf_wdata, 32'hCAFE);
`ifdef RF_WB_BYPASS_EN
        chk("t6_stall2", stall2, 1'b0);
        chk("t6_byp_hit2", byp_hit2, 1'b1);
        chk("t6_byp_data2", byp_data2, 32'hCAFE);
`else
        chk("t6_stall2", stall2, 1'b1);
        chk("t6_byp_hit2", byp_hit2, 1'b0);
        chk("t6_byp_data2", byp_data2, 32'd0);
`endif
        tick(); settle();
        chk("t6_stall2_after", stall2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
